// File: rtl/seq_multiplier_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller.
// Holds the default sizing, the FSM state encoding, the bundle of
// state-decoded control outputs, and the decode function that maps a
// state onto that bundle.
package seq_multiplier_ctrl_pkg;

  localparam int N_DEF     = 24;  // operand width = iteration count
  localparam int CNT_W_DEF = 5;   // 2**CNT_W_DEF >= N_DEF

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_MULT = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Every output except Bsel is a pure function of state.
  typedef struct packed {
    logic loadA;
    logic loadB;
    logic initP;
    logic loadP;
    logic shiftA;
    logic busy;
    logic ready;
    logic done;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_IDLE: c.ready = 1'b1;
      S_LOAD: begin
        c.loadA = 1'b1;
        c.loadB = 1'b1;
        c.initP = 1'b1;
        c.busy  = 1'b1;
      end
      S_MULT: begin
        c.loadP  = 1'b1;
        c.shiftA = 1'b1;
        c.busy   = 1'b1;
      end
      S_DONE: begin
        // No strobes: the datapath holds {P,A} as the result.
        c.done  = 1'b1;
        c.ready = 1'b1;
      end
      default: c.ready = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_multiplier_ctrl_iter.sv
// mul_iter_counter: iteration counter for the multiplier controller.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears the count
//   clr  : synchronous clear (wins over en)
//   en   : increment by one
//   term : high while the count equals N-1 (last iteration)
// CNT_W must be wide enough that 2**CNT_W >= N.
module mul_iter_counter
  import seq_multiplier_ctrl_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  assign term = (cnt == LAST);

endmodule

// File: rtl/seq_multiplier_ctrl.sv
// Control unit for the N-bit sequential shift-add multiplier datapath.
// A start request loads both operands and clears P, then N add/shift
// iterations run one per clock, each adding B or zero depending on the
// current multiplier bit A0. The controller then parks in DONE with all
// strobes low so the datapath holds the 2N-bit product, and accepts a new
// start directly from there.
//   clk, rst        : clock / asynchronous active-high reset
//   start           : new request, honoured only while ready=1
//   A0              : LSB of datapath A register
//   loadA/loadB     : load operand registers from their buses
//   initP           : clear P
//   loadP/shiftA    : one add/shift iteration
//   Bsel            : adder operand select (B when 1, zero when 0)
//   busy/ready/done : status
module seq_multiplier_ctrl
  import seq_multiplier_ctrl_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic A0,
  output logic loadA,
  output logic loadB,
  output logic initP,
  output logic loadP,
  output logic shiftA,
  output logic Bsel,
  output logic busy,
  output logic ready,
  output logic done
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   cnt_clr, cnt_en, cnt_term;

  // Clear on LOAD so each run starts at zero, and on the final iteration
  // so the counter is already zero while parked in DONE.
  assign cnt_en  = (state_q == S_MULT);
  assign cnt_clr = (state_q == S_LOAD) || (cnt_en && cnt_term);

  mul_iter_counter #(.N(N), .CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is ignored in LOAD/MULT (no queuing).
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
      S_LOAD:  state_d = S_MULT;
      S_MULT:  state_d = cnt_term ? S_DONE : S_MULT;
      S_DONE:  state_d = start ? S_LOAD : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; Bsel is the only output with an input dependency.
  always_comb begin
    ctrl = decode_ctrl(state_q);
    Bsel = (state_q == S_MULT) && A0;
  end

  assign loadA  = ctrl.loadA;
  assign loadB  = ctrl.loadB;
  assign initP  = ctrl.initP;
  assign loadP  = ctrl.loadP;
  assign shiftA = ctrl.shiftA;
  assign busy   = ctrl.busy;
  assign ready  = ctrl.ready;
  assign done   = ctrl.done;

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// Bench for seq_multiplier_ctrl: a behavioural shift-add datapath is
// wired to the controller's strobes, directed operand pairs are issued
// with hand-computed products, and a monitor checks each rising done
// against a scoreboard queue (product, done cycle, busy length, Bsel
// sequence).
module tb_seq_multiplier_ctrl;

  localparam int N = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic A0;
  logic loadA, loadB, initP, loadP, shiftA, Bsel, busy, ready, done;

  always #5 clk = ~clk;

  seq_multiplier_ctrl #(.N(N), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .A0(A0),
    .loadA(loadA), .loadB(loadB), .initP(initP), .loadP(loadP),
    .shiftA(shiftA), .Bsel(Bsel), .busy(busy), .ready(ready), .done(done)
  );

  // Behavioural datapath
  logic [N-1:0] abus = '0, bbus = '0;
  logic [N-1:0] ra = '0, rb = '0, rp = '0;
  logic [N:0]   sum;
  logic [2*N-1:0] resultbus;

  assign sum       = {1'b0, rp} + (Bsel ? {1'b0, rb} : '0);
  assign A0        = ra[0];
  assign resultbus = {rp, ra};

  always @(posedge clk) begin
    if (loadB) rb <= bbus;
    if (loadA)       ra <= abus;
    else if (shiftA) ra <= {sum[0], ra[N-1:1]};
    if (initP)       rp <= '0;
    else if (loadP)  rp <= sum[N:1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic [2*N-1:0] res;
    int             cyc;
    logic [N-1:0]   pat;
  } exp_t;

  exp_t sb[$];

  // Monitor
  logic          prev_done = 1'b0;
  int            busy_cnt = 0;
  int            idx = 0;
  logic [N-1:0]  pat = '0;
  logic          excl_bad = 1'b0;
  exp_t          e;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0; idx = 0; pat = '0;
    end else begin
      if ((loadA | loadB | initP) & (loadP | shiftA)) excl_bad = 1'b1;
      if (busy) busy_cnt++;
      if (shiftA) begin
        if (idx < N) pat[idx] = Bsel;
        idx++;
      end
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("product", 64'(resultbus), 64'(e.res));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("busy_len", 64'(busy_cnt), 64'(N + 1));
          chk("bsel_seq", 64'(pat), 64'(e.pat));
        end
        busy_cnt = 0; idx = 0; pat = '0;
      end
    end
    prev_done = done;
  end

  // Stimulus helpers
  task automatic issue(input logic [N-1:0] a, b, input logic [2*N-1:0] res,
                       input logic [N-1:0] bp);
    exp_t x;
    @(negedge clk);
    abus = a; bbus = b; start = 1'b1;
    x.res = res; x.cyc = cyc + N + 2; x.pat = bp;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({nm, "_timeout"}, 64'(n), 64'd60 + 64'd1);
  endtask

  task automatic do_mul(input logic [N-1:0] a, b, input logic [2*N-1:0] res,
                        input logic [N-1:0] bp, input string nm);
    issue(a, b, res, bp);
    @(negedge clk);
    wait_done(nm);
  endtask

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk);
    chk("reset_outputs",
        64'({loadA, loadB, initP, loadP, shiftA, Bsel, busy, ready, done}),
        64'(9'b000000010));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'({ready, busy, done}), 64'(3'b100));

    do_mul(24'd5, 24'd3, 48'h00000000000F, 24'd5, "basic");
    do_mul(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 24'hFFFFFF, "max");
    do_mul(24'h000000, 24'h123456, 48'h000000000000, 24'h000000, "zero");
    do_mul(24'hAAAAAA, 24'h000002, 48'h000001555554, 24'hAAAAAA, "alt");

    // Start while busy: second pulse at MULT cycle 10 must be ignored
    issue(24'h000010, 24'h000020, 48'h000000000200, 24'h000010);
    repeat (10) @(negedge clk);
    abus = 24'hFFFFFF; bbus = 24'hFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");

    // Reset at MULT cycle 7
    issue(24'h001234, 24'h000777, 48'h0, 24'h0);
    repeat (7) @(negedge clk);
    chk("mid_shift_active", 64'({shiftA, busy}), 64'(2'b11));
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    chk("mid_reset_outputs",
        64'({loadA, loadB, initP, loadP, shiftA, Bsel, busy, ready, done}),
        64'(9'b000000010));
    @(negedge clk);
    rst = 1'b0;
    do_mul(24'd7, 24'd9, 48'h00000000003F, 24'd7, "after_reset");

    // Hold DONE, then start directly from DONE
    repeat (5) @(negedge clk);
    chk("done_hold", 64'({done, ready, busy}), 64'(3'b110));
    chk("result_hold", 64'(resultbus), 64'h00000000003F);
    issue(24'h000100, 24'h000100, 48'h000000010000, 24'h000100);
    chk("b2b_load", 64'({loadA, loadB, initP, busy, ready, done}), 64'(6'b111100));
    wait_done("b2b");

    repeat (3) @(negedge clk);
    chk("strobe_exclusive", 64'(excl_bad), 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_ctrl.md
Name: seq_multiplier_ctrl

Overview:
Control unit for the 24-bit sequential shift-add multiplier datapath. It accepts a start request, loads the operands, and issues 24 add/shift iterations, one per clock, using the datapath's A0 feedback. It then signals completion while the 48-bit result is valid on the datapath result bus. It sits beside the datapath inside the multiplier top; the top wires the control outputs directly to the matching datapath inputs.

Parameters:
N, 24, operand width = number of add/shift iterations
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W >= N

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new multiplication; sampled only when ready=1
A0  input  1  LSB of the datapath A register (current multiplier bit)
loadA  output  1  load the A register from Abus
loadB  output  1  load the B register from Bbus
initP  output  1  clear the P register
loadP  output  1  P <= (sum)[N:1]
shiftA  output  1  A <= {sum[0], A[N-1:1]}
Bsel  output  1  selects B (1) or zero (0) as the adder operand
busy  output  1  a multiplication is in progress
ready  output  1  controller will accept start this cycle
done  output  1  result bus holds a valid product

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high. While rst=1, state=IDLE and cnt=0.
- Reset values: loadA=loadB=initP=loadP=shiftA=Bsel=busy=done=0; ready=1.
- States: IDLE, LOAD, MULT, DONE. The state register and cnt are the only flops.
- IDLE:
  - ready=1; all strobes 0.
  - start=1 -> LOAD.
- LOAD (exactly 1 cycle):
  - loadA=loadB=initP=1; busy=1; ready=0.
  - cnt<=0; -> MULT unconditionally.
- MULT (exactly N cycles):
  - loadP=shiftA=1; Bsel=A0 (combinational from A0); busy=1; ready=0.
  - cnt<=cnt+1 each cycle.
  - When cnt==N-1 -> DONE and cnt<=0.
- DONE:
  - done=1; ready=1; busy=0; all strobes 0, so the datapath holds {P,A}.
  - Stays in DONE until start=1, then -> LOAD directly (back-to-back operation).
- Latency: start is sampled at edge E0. The load happens at E1. The iterations happen at E2..E(N+1). done is high after edge E(N+1), i.e. N+1 cycles after the start edge (25 for N=24).
- start while busy=1 (LOAD or MULT): ignored; no queuing, no restart.
- Strobe exclusivity: loadA/loadB/initP never assert together with loadP/shiftA.
- Datapath contract: initP has priority over loadP and loadA over shiftA, so the LOAD cycle is unambiguous. The controller never relies on either priority.
- Reset mid-operation: immediate return to IDLE with cnt=0 and done=0. Datapath contents are undefined until the next LOAD.
- Outputs are decoded from state only, except Bsel, which depends on A0 in MULT.
- No illegal-state lockup: any unused encoding decodes to IDLE on the next clock.

Decomposition:
- Shared package: state encoding constants (IDLE=2'b00, LOAD=2'b01, MULT=2'b10, DONE=2'b11), default N=24, CNT_W=5.
- One natural sub-module: mul_iter_counter. It is a CNT_W-bit counter with synchronous clear and enable inputs and a terminal flag for cnt==N-1. The FSM instantiates it.
- The multiplier top instantiates seq_multiplier_ctrl plus the datapath. The bench drives that top.

Test Plan:
- Basic product: rst pulse, then start with A=5, B=3 -> done rises 25 cycles after the start edge; resultbus=48'h00000000000F; busy high for exactly 25 cycles.
- Maximum operands: A=B=24'hFFFFFF -> resultbus=48'hFFFFFE000001; Bsel=1 on all 24 MULT cycles.
- Zero and alternating operands: A=0, B=24'h123456 -> result 0 and Bsel=0 throughout. Then A=24'hAAAAAA, B=2 -> result 48'h000001555554; Bsel toggles 0,1,0,1...
- Start while busy: pulse start at MULT cycle 10 with new operands on the buses -> no restart; the original product appears at the original done time.
- Reset mid-operation: assert rst at MULT cycle 7 -> all outputs return to their reset values immediately, ready=1. A new start with A=7, B=9 then gives 48'h00000000003F.
- Back-to-back: hold done, then start from DONE with A=24'h000100, B=24'h000100 -> LOAD follows directly (no IDLE cycle); result 48'h000000010000.
